// File: rtl/div_sequencer_pkg.sv
// rtl/div_sequencer_pkg.sv - shared states, defaults and sign helpers for the divide sequencer
package div_sequencer_pkg;

  localparam int          DIV_CYCLES_DEFAULT = 32;
  localparam int          WATCHDOG_DEFAULT   = 48;
  localparam logic [31:0] DBZ_QUOTIENT       = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_RUN   = 3'd2,
    ST_FIXUP = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Two's complement negate with natural 32-bit wrap (so -0x80000000 stays 0x80000000)
  function automatic logic [31:0] negate(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  // Magnitude of an operand; unsigned operands pass through untouched
  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? negate(x) : x;
  endfunction

endpackage

// File: rtl/div_sequencer_rr_arbiter2.sv
// rtl/div_sequencer_rr_arbiter2.sv - two-way round-robin grant with pointer update on accept
module div_sequencer_rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1,
  output logic grant_id
);

  logic ptr;
  logic any_valid;

  // Pointer names the preferred requester when both ask; a lone requester always wins
  always_comb begin
    any_valid = valid0 | valid1;
    grant_id  = (valid0 & valid1) ? ptr : valid1;
    grant0    = enable & any_valid & ~grant_id;
    grant1    = enable & any_valid & grant_id;
  end

  // Pointer moves past the winner on every accepted grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= 1'b0;
    end else if (enable & any_valid) begin
      ptr <= ~grant_id;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - shares one unsigned divide core between two requesters with sign fix-up
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT,
  parameter int WATCHDOG   = WATCHDOG_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_signed,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_quotient,
  output logic [31:0] resp_remainder,
  output logic        resp_dbz,
  output logic        resp_err,
  output logic        busy,
  output logic        div_reset,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_ready
);

  // Counter is wide enough for the longer of a nominal run and the abort limit
  localparam int               CNT_MAX = (WATCHDOG > DIV_CYCLES) ? WATCHDOG : DIV_CYCLES;
  localparam int               CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WATCHDOG - 1);

  state_t            state, state_nxt;
  logic              arb_enable, grant0, grant1, grant_id, accept;
  logic [31:0]       sel_a, sel_b;
  logic              sel_signed;
  logic              id_q, neg_q, neg_r, dbz_q, err_q;
  logic [31:0]       mag_a, mag_b, quo_q, rem_q;
  logic [CNT_W-1:0]  cnt;

  // Grants only in IDLE and never while reset is asserted
  assign arb_enable = (state == ST_IDLE) & reset;
  assign accept     = grant0 | grant1;

  div_sequencer_rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .enable   (arb_enable),
    .valid0   (req0_valid),
    .valid1   (req1_valid),
    .grant0   (grant0),
    .grant1   (grant1),
    .grant_id (grant_id)
  );

  // Operand mux follows the arbiter decision
  always_comb begin
    sel_a      = grant_id ? req1_a      : req0_a;
    sel_b      = grant_id ? req1_b      : req0_b;
    sel_signed = grant_id ? req1_signed : req0_signed;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded outputs; core is held in restart outside RUN
  always_comb begin
    state_nxt  = state;
    busy       = (state != ST_IDLE);
    div_reset  = (state != ST_RUN);
    resp_valid = (state == ST_RESP);
    req0_ready = grant0;
    req1_ready = grant1;
    case (state)
      ST_IDLE:  if (accept) state_nxt = (sel_b == 32'd0) ? ST_RESP : ST_SETUP;
      ST_SETUP: state_nxt = ST_RUN;
      ST_RUN: begin
        if (div_ready)          state_nxt = ST_FIXUP;
        else if (cnt == WD_LAST) state_nxt = ST_RESP;
      end
      ST_FIXUP: state_nxt = ST_RESP;
      ST_RESP:  if (resp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Operation capture, core result capture, watchdog abort and sign fix-up
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_q  <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dbz_q <= 1'b0;
      err_q <= 1'b0;
      mag_a <= 32'd0;
      mag_b <= 32'd0;
      quo_q <= 32'd0;
      rem_q <= 32'd0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            id_q  <= grant_id;
            mag_a <= magnitude(sel_a, sel_signed);
            mag_b <= magnitude(sel_b, sel_signed);
            neg_q <= sel_signed & (sel_a[31] ^ sel_b[31]);
            neg_r <= sel_signed & sel_a[31];
            dbz_q <= (sel_b == 32'd0);
            err_q <= 1'b0;
            cnt   <= '0;
            // Divide-by-zero result; a real division overwrites both later
            quo_q <= DBZ_QUOTIENT;
            rem_q <= sel_a;
          end
        end
        ST_RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (div_ready) begin
            quo_q <= div_quotient;
            rem_q <= div_remainder;
          end else if (cnt == WD_LAST) begin
            quo_q <= 32'd0;
            rem_q <= 32'd0;
            err_q <= 1'b1;
          end
        end
        ST_FIXUP: begin
          if (neg_q) quo_q <= negate(quo_q);
          if (neg_r) rem_q <= negate(rem_q);
        end
        default: ;
      endcase
    end
  end

  assign div_a          = mag_a;
  assign div_b          = mag_b;
  assign resp_id        = id_q;
  assign resp_quotient  = quo_q;
  assign resp_remainder = rem_q;
  assign resp_dbz       = resp_valid & dbz_q;
  assign resp_err       = resp_valid & err_q;

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Controller that shares the team's 32-bit iterative unsigned divide core between two requesters. It arbitrates requests round-robin and restarts the core per operation. It handles signed operands by magnitude conversion and result fix-up, short-circuits divide-by-zero, and returns results on a valid/ready response channel. It sits between the ALU/issue logic and the divide core.

Parameters:
DIV_CYCLES, 32, expected core cycles from div_reset release to div_ready
WATCHDOG, 48, max cycles in RUN before aborting with resp_err

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  32  requester 0 dividend
req0_b  input  32  requester 0 divisor
req0_signed  input  1  requester 0 operands are two's complement
req1_valid, req1_ready, req1_a, req1_b, req1_signed  same as requester 0
resp_valid  output  1  result available
resp_ready  input  1  consumer takes result
resp_id  output  1  requester index of result
resp_quotient  output  32  quotient
resp_remainder  output  32  remainder
resp_dbz  output  1  divisor was zero
resp_err  output  1  watchdog abort
busy  output  1  state != IDLE
div_reset  output  1  active-high restart to core
div_a  output  32  core dividend (magnitude)
div_b  output  32  core divisor (magnitude)
div_quotient  input  32  core quotient
div_remainder  input  32  core remainder
div_ready  input  1  core done

Behaviour:
- Reset (reset=0, async): state IDLE; rr pointer=0; all outputs 0 except div_reset=1 (core held). Registers clear immediately; no response is emitted for an aborted op.
- States: IDLE, SETUP, RUN, FIXUP, RESP.
- IDLE: div_reset=1. If any reqN_valid: grant by round-robin (pointer = preferred index; lone requester always wins). Assert reqN_ready combinationally for the granted requester only. Capture a, b, signed, id; compute magnitudes and neg_q = signed & (a[31]^b[31]), neg_r = signed & a[31]. Advance pointer to !id. If b==0 -> RESP directly: quotient=32'hFFFFFFFF, remainder=a (raw), dbz=1. Else -> SETUP.
- SETUP (1 cycle): div_a/div_b driven from captured magnitudes, held stable until FIXUP. div_reset=1 this cycle, 0 from next. -> RUN.
- RUN: div_reset=0; cycle counter increments. On div_ready=1, capture div_quotient/div_remainder -> FIXUP. If counter reaches WATCHDOG first -> RESP with err=1, quotient=remainder=0.
- FIXUP (1 cycle): quotient = neg_q ? -q : q; remainder = neg_r ? -r : r (32-bit wrap). div_reset=1. -> RESP.
- RESP: resp_valid=1, outputs stable while resp_ready=0. On resp_ready=1, deassert next cycle -> IDLE. No new grant in the same cycle.
- Latency, nonzero divisor: accept at cycle T; SETUP T+1; RUN from T+2; resp_valid at div_ready cycle +2 (nominal T+DIV_CYCLES+4). Divide-by-zero: resp_valid at T+1.
- Signed overflow: -2^31 / -1 yields quotient 0x80000000, remainder 0 (natural wrap, no flag).
- Unsigned mode: no sign logic. Signed mode: magnitude of 0x80000000 is 0x80000000.
- Requests are never queued. A non-granted valid stays pending, with its ready low.
- resp_dbz/resp_err are valid only with resp_valid and are 0 otherwise.

Decomposition:
- Shared package: state encoding constants, DIV_CYCLES/WATCHDOG defaults, DBZ_QUOTIENT=32'hFFFFFFFF.
- One sub-module is natural: rr_arbiter2 (2-way round-robin grant with pointer update on accept).
- Negate/magnitude uses the existing add/subtract blocks. The divide core stays external, connected via div_* ports.

Test Plan:
- req0 unsigned a=100 b=7 -> resp_id=0, q=14, r=2, dbz=0; resp_valid exactly 2 cycles after div_ready.
- req1 signed a=-7 (0xFFFFFFF9) b=2 -> q=0xFFFFFFFD, r=0xFFFFFFFF. Signed a=7 b=-2 -> q=0xFFFFFFFD, r=1.
- req0 a=0x1234 b=0 -> resp_valid at T+1, q=0xFFFFFFFF, r=0x1234, dbz=1; div_reset never released.
- Both valid every cycle for 4 ops -> grants alternate 0,1,0,1. Only the granted requester sees ready. resp_ready=0 for 5 cycles holds all resp outputs stable.
- Signed a=0x80000000 b=0xFFFFFFFF -> q=0x80000000, r=0. Core model withholding div_ready -> resp_err=1 after WATCHDOG RUN cycles.
- reset asserted mid-RUN -> busy, resp_valid and req*_ready drop immediately, div_reset=1. After release, a new op completes correctly.
